// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: EX-stage ALU with merged ALUOp/FunCode decode, a registered
// single-cycle result path and an iterative multiply/divide sequencer that
// owns the HI/LO registers.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   valid_in / in_ready op handshake; accept when both are high
//   flush               abort any in-flight op, suppress its completion
//   ALUOp, FunCode      main-decoder op class and R-type funct field
//   op_a, op_b          operands, captured on the accept edge
//   result, zero        registered result and its zero flag
//   valid_out           one-cycle completion pulse qualifying result/zero/flags
//   illegal_op          unknown funct under ALUOp=1
//   div_by_zero         divide with a zero divisor
//   busy                multiply/divide sequencer occupied
//   hi, lo              HI/LO registers
module alu_ctrl_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             in_ready,
  input  logic             flush,
  input  logic [2:0]       ALUOp,
  input  logic [5:0]       FunCode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid_out,
  output logic             illegal_op,
  output logic             div_by_zero,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  // Magnitude of an operand; unsigned ops pass straight through.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_ill, is_multi, is_mul, is_sgn;
  logic                    accept, acc_single, acc_dbz;

  assign a_s = op_a;
  assign b_s = op_b;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = valid_in && in_ready && !flush;

  // Decode: funct 24..27 are MULT/MULTU/DIV/DIVU; bit1 picks divide, bit0 unsigned.
  always_comb begin
    alu_res  = op_a + op_b;
    alu_ill  = 1'b0;
    is_multi = 1'b0;
    is_mul   = ~FunCode[1];
    is_sgn   = ~FunCode[0];
    case (ALUOp)
      3'd1: begin
        case (FunCode)
          6'd36:        alu_res = op_a & op_b;
          6'd37:        alu_res = op_a | op_b;
          6'd38:        alu_res = op_a ^ op_b;
          6'd39:        alu_res = ~(op_a | op_b);
          6'd32, 6'd33: alu_res = op_a + op_b;
          6'd34, 6'd35: alu_res = op_a - op_b;
          6'd42:        alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
          6'd43:        alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
          6'd16:        alu_res = hi;
          6'd18:        alu_res = lo;
          6'd24, 6'd25, 6'd26, 6'd27: is_multi = 1'b1;
          default: begin
            alu_res = op_a & op_b;
            alu_ill = 1'b1;
          end
        endcase
      end
      3'd3:    alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      3'd4:    alu_res = op_a & op_b;
      3'd5:    alu_res = op_a | op_b;
      default: alu_res = op_a + op_b;
    endcase
  end

  assign acc_single = accept && !is_multi;
  assign acc_dbz    = accept && is_multi && !is_mul && (op_b == '0);

  // Iteration datapath: acc_p0 is the product high half / partial remainder,
  // lq_p0 the multiplier / dividend shifting into the quotient, mcand_p0 the
  // multiplicand / divisor magnitude.
  logic [WIDTH-1:0] acc_p0, lq_p0, mcand_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             neg_q_p0, neg_r_p0;
  logic             last;

  logic [WIDTH:0]     mul_sum, div_sh;
  logic [WIDTH-1:0]   mul_acc_n, mul_lq_n, div_acc_n, div_lq_n, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0]   quo_f, rem_f;

  assign last = (cnt_p0 == CNT_W'(WIDTH - 1));

  assign mul_sum   = {1'b0, acc_p0} + {1'b0, (lq_p0[0] ? mcand_p0 : '0)};
  assign mul_acc_n = mul_sum[WIDTH:1];
  assign mul_lq_n  = {mul_sum[0], lq_p0[WIDTH-1:1]};

  // Restoring step: the shifted remainder never exceeds 2*divisor, so a
  // successful subtraction always fits back into WIDTH bits.
  assign div_sh    = {acc_p0, lq_p0[WIDTH-1]};
  assign div_ge    = (div_sh >= {1'b0, mcand_p0});
  assign div_diff  = div_sh[WIDTH-1:0] - mcand_p0;
  assign div_acc_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_lq_n  = {lq_p0[WIDTH-2:0], div_ge};

  assign prod   = {mul_acc_n, mul_lq_n};
  assign prod_f = neg_q_p0 ? -prod : prod;
  assign quo_f  = neg_q_p0 ? -div_lq_n : div_lq_n;
  assign rem_f  = neg_r_p0 ? -div_acc_n : div_acc_n;

  // ---- stage p0: operand capture and one iteration per cycle ----
  always_ff @(posedge clk) begin
    if (accept && is_multi) begin
      acc_p0   <= '0;
      lq_p0    <= mag(op_a, is_sgn);
      mcand_p0 <= mag(op_b, is_sgn);
      cnt_p0   <= '0;
      neg_q_p0 <= is_sgn && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_r_p0 <= is_sgn && op_a[WIDTH-1];
    end else if (state == MUL) begin
      acc_p0 <= mul_acc_n;
      lq_p0  <= mul_lq_n;
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end else if (state == DIV) begin
      acc_p0 <= div_acc_n;
      lq_p0  <= div_lq_n;
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_multi)
              state_nxt = is_mul ? MUL : ((op_b == '0) ? DONE : DIV);
      MUL:  if (last) state_nxt = DONE;
      DIV:  if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // ---- stage p1: registered outputs; HI/LO written on the edge into DONE ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      result      <= '0;
      zero        <= 1'b1;
      valid_out   <= 1'b0;
      illegal_op  <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      state     <= state_nxt;
      valid_out <= 1'b0;
      if (!flush) begin
        if (acc_single) begin
          result      <= alu_res;
          zero        <= (alu_res == '0);
          valid_out   <= 1'b1;
          illegal_op  <= alu_ill;
          div_by_zero <= 1'b0;
        end else if (acc_dbz) begin
          hi          <= op_a;
          lo          <= '1;
          result      <= '1;
          zero        <= 1'b0;
          valid_out   <= 1'b1;
          illegal_op  <= 1'b0;
          div_by_zero <= 1'b1;
        end else if (state == MUL && last) begin
          hi          <= prod_f[2*WIDTH-1:WIDTH];
          lo          <= prod_f[WIDTH-1:0];
          result      <= prod_f[WIDTH-1:0];
          zero        <= (prod_f[WIDTH-1:0] == '0);
          valid_out   <= 1'b1;
          illegal_op  <= 1'b0;
          div_by_zero <= 1'b0;
        end else if (state == DIV && last) begin
          hi          <= rem_f;
          lo          <= quo_f;
          result      <= quo_f;
          zero        <= (quo_f == '0);
          valid_out   <= 1'b1;
          illegal_op  <= 1'b0;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed cases plus randomized ops
// compared against an arithmetic reference model. A second 8-bit instance
// covers the width-dependent latency.
module tb_alu_ctrl_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, valid_in, flush;
  logic [2:0]   aluop;
  logic [5:0]   funcode;
  logic [W-1:0] a, b;
  logic         in_ready, zero, valid_out, illegal_op, div_by_zero, busy;
  logic [W-1:0] result, hi, lo;

  logic         valid8;
  logic [2:0]   aluop8;
  logic [5:0]   fun8;
  logic [7:0]   a8, b8;
  logic         rdy8, zero8, vo8, ill8, dbz8, busy8;
  logic [7:0]   res8, hi8, lo8;

  alu_ctrl_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
    .flush(flush), .ALUOp(aluop), .FunCode(funcode), .op_a(a), .op_b(b),
    .result(result), .zero(zero), .valid_out(valid_out),
    .illegal_op(illegal_op), .div_by_zero(div_by_zero), .busy(busy),
    .hi(hi), .lo(lo)
  );

  alu_ctrl_seq #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid8), .in_ready(rdy8),
    .flush(1'b0), .ALUOp(aluop8), .FunCode(fun8), .op_a(a8), .op_b(b8),
    .result(res8), .zero(zero8), .valid_out(vo8),
    .illegal_op(ill8), .div_by_zero(dbz8), .busy(busy8),
    .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi, mlo, mres;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference for single-cycle ops, from the decode table.
  function automatic void ref_single(input logic [2:0] op, input logic [5:0] fn,
                                     input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] r, output logic ill);
    ill = 1'b0;
    case (op)
      3'd3: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd1: begin
        case (fn)
          6'd36: r = x & y;
          6'd37: r = x | y;
          6'd38: r = x ^ y;
          6'd39: r = ~(x | y);
          6'd32, 6'd33: r = x + y;
          6'd34, 6'd35: r = x - y;
          6'd42: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
          6'd43: r = (x < y) ? 32'd1 : 32'd0;
          6'd16: r = mhi;
          6'd18: r = mlo;
          default: begin r = x & y; ill = 1'b1; end
        endcase
      end
      default: r = x + y;
    endcase
  endfunction

  // Reference for MULT/MULTU/DIV/DIVU using exact wide integer arithmetic.
  function automatic void ref_multi(input logic [5:0] fn, input logic [63:0] x_in,
                                    input logic [63:0] y_in, input int w,
                                    output logic [63:0] rhi, output logic [63:0] rlo,
                                    output logic rdbz);
    logic [63:0] m;
    logic [127:0] tx, ty;
    logic signed [127:0] x, y, p, p2, q, r;
    bit sg;
    m  = (64'd1 << w) - 64'd1;
    sg = (fn == 6'd24) || (fn == 6'd26);
    tx = {64'd0, x_in & m};
    ty = {64'd0, y_in & m};
    if (sg) begin
      x = $signed(tx << (128 - w)) >>> (128 - w);
      y = $signed(ty << (128 - w)) >>> (128 - w);
    end else begin
      x = $signed(tx);
      y = $signed(ty);
    end
    rdbz = 1'b0;
    if (fn == 6'd24 || fn == 6'd25) begin
      p   = x * y;
      p2  = p >>> w;
      rlo = p[63:0] & m;
      rhi = p2[63:0] & m;
    end else if (y == 0) begin
      rdbz = 1'b1;
      rlo  = m;
      rhi  = x_in & m;
    end else begin
      q   = x / y;
      r   = x % y;
      rlo = q[63:0] & m;
      rhi = r[63:0] & m;
    end
  endfunction

  // Issue one op on the 32-bit instance and check its completion.
  task automatic run_op(input logic [2:0] op, input logic [5:0] fn,
                        input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [63:0] ehi, elo;
    logic eill, edbz;
    bit multi;
    int cyc, elat;
    multi = (op == 3'd1) && (fn >= 6'd24) && (fn <= 6'd27);
    chk("rdy_pre", 64'(in_ready), 64'd1);
    valid_in = 1'b1; aluop = op; funcode = fn; a = x; b = y;
    step();
    if (!multi) begin
      valid_in = 1'b0;
      ref_single(op, fn, x, y, er, eill);
      chk("vo", 64'(valid_out), 64'd1);
      chk("res", 64'(result), 64'(er));
      chk("zero", 64'(zero), 64'(er == 32'd0));
      chk("ill", 64'(illegal_op), 64'(eill));
      chk("dbz_s", 64'(div_by_zero), 64'd0);
      mres = er;
    end else begin
      ref_multi(fn, 64'(x), 64'(y), 32, ehi, elo, edbz);
      elat = edbz ? 1 : W + 1;
      cyc  = 1;
      // Inputs churn while busy: must be ignored and not disturb the op.
      valid_in = 1'b1; a = $urandom; b = $urandom;
      aluop = 3'($urandom); funcode = 6'($urandom);
      while (!valid_out && cyc < W + 8) begin
        chk("rdy_busy", 64'(in_ready), 64'd0);
        chk("busy", 64'(busy), 64'd1);
        step();
        cyc++;
        a = $urandom; b = $urandom;
      end
      valid_in = 1'b0;
      chk("lat", 64'(cyc), 64'(elat));
      chk("vo_m", 64'(valid_out), 64'd1);
      chk("rdy_done", 64'(in_ready), 64'd0);
      chk("res_m", 64'(result), elo);
      chk("hi", 64'(hi), ehi);
      chk("lo", 64'(lo), elo);
      chk("dbz", 64'(div_by_zero), 64'(edbz));
      chk("ill_m", 64'(illegal_op), 64'd0);
      chk("zero_m", 64'(zero), 64'(elo == 64'd0));
      mhi = ehi[31:0]; mlo = elo[31:0]; mres = elo[31:0];
      step();
      chk("vo_after", 64'(valid_out), 64'd0);
      chk("rdy_after", 64'(in_ready), 64'd1);
    end
  endtask

  function automatic logic [31:0] pick_opnd();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal [16];
    logic [2:0] bop [4];
    logic [5:0] bfn [4];
    logic [31:0] er;
    logic eill, seen;
    logic [63:0] ehi, elo;
    logic edbz;
    int cyc;
    legal = '{6'd36, 6'd37, 6'd38, 6'd39, 6'd32, 6'd33, 6'd34, 6'd35,
              6'd42, 6'd43, 6'd16, 6'd18, 6'd24, 6'd25, 6'd26, 6'd27};

    rst_n = 1'b0; valid_in = 1'b0; flush = 1'b0; aluop = '0; funcode = '0; a = '0; b = '0;
    valid8 = 1'b0; aluop8 = '0; fun8 = '0; a8 = '0; b8 = '0;
    step(); step();
    chk("rst_res", 64'(result), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_vo", 64'(valid_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    mhi = '0; mlo = '0; mres = '0;
    step();

    // Directed cases.
    run_op(3'd1, 6'd34, 32'd5, 32'd7);
    run_op(3'd1, 6'd42, 32'd5, 32'd7);
    run_op(3'd1, 6'd24, 32'hFFFF_FFFD, 32'd7);
    run_op(3'd1, 6'd16, 32'd0, 32'd0);
    run_op(3'd1, 6'd26, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd1, 6'd27, 32'd7, 32'd0);
    run_op(3'd1, 6'd26, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd1, 6'd63, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op(3'd3, 6'd0, 32'h8000_0000, 32'd1);

    // No completion: valid_out low, result held.
    step();
    chk("idle_vo", 64'(valid_out), 64'd0);
    chk("idle_res", 64'(result), 64'(mres));

    // Back-to-back single-cycle ops on consecutive cycles.
    bop = '{3'd1, 3'd1, 3'd1, 3'd1};
    bfn = '{6'd32, 6'd37, 6'd38, 6'd39};
    valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      aluop = bop[i]; funcode = bfn[i]; a = $urandom; b = $urandom;
      ref_single(bop[i], bfn[i], a, b, er, eill);
      step();
      chk("b2b_vo", 64'(valid_out), 64'd1);
      chk("b2b_res", 64'(result), 64'(er));
      mres = er;
    end
    valid_in = 1'b0;

    // Flush a MULTU in cycle 10.
    valid_in = 1'b1; aluop = 3'd1; funcode = 6'd25; a = $urandom; b = $urandom;
    step();
    valid_in = 1'b0;
    for (int c = 1; c < 10; c++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_rdy", 64'(in_ready), 64'd1);
    chk("fl_vo", 64'(valid_out), 64'd0);
    chk("fl_busy", 64'(busy), 64'd0);
    chk("fl_hi", 64'(hi), 64'(mhi));
    chk("fl_lo", 64'(lo), 64'(mlo));
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      seen |= valid_out;
      step();
    end
    chk("fl_novo", 64'(seen), 64'd0);

    // flush beats valid_in in the same cycle.
    valid_in = 1'b1; aluop = 3'd0; a = 32'd1; b = 32'd2; flush = 1'b1;
    step();
    valid_in = 1'b0; flush = 1'b0;
    chk("flpri_vo", 64'(valid_out), 64'd0);
    chk("flpri_res", 64'(result), 64'(mres));
    chk("flpri_rdy", 64'(in_ready), 64'd1);

    // Randomized ops.
    for (int n = 0; n < 60; n++) begin
      logic [2:0] op;
      logic [5:0] fn;
      op = 3'($urandom_range(0, 7));
      if (op != 3'd1 && $urandom_range(0, 2) == 0) op = 3'd1;
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal[$urandom_range(0, 15)];
      run_op(op, fn, pick_opnd(), pick_opnd());
    end

    // Reset in cycle 10 of a MULTU.
    valid_in = 1'b1; aluop = 3'd1; funcode = 6'd25; a = $urandom | 32'h1; b = $urandom | 32'h1;
    step();
    valid_in = 1'b0;
    for (int c = 1; c < 10; c++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rs_hi", 64'(hi), 64'd0);
    chk("rs_lo", 64'(lo), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_rdy", 64'(in_ready), 64'd1);
    chk("rs_zero", 64'(zero), 64'd1);
    mhi = '0; mlo = '0; mres = '0;
    step();

    // 8-bit instance: directed MULT -3*7 then a few random mul/div.
    for (int n = 0; n < 7; n++) begin
      logic [5:0] fn;
      logic [7:0] x, y;
      int elat;
      fn = (n == 0) ? 6'd24 : 6'(24 + $urandom_range(0, 3));
      x  = (n == 0) ? 8'hFD : 8'($urandom);
      y  = (n == 0) ? 8'd7  : ((n == 3) ? 8'd0 : 8'($urandom));
      ref_multi(fn, 64'(x), 64'(y), 8, ehi, elo, edbz);
      elat = edbz ? 1 : 9;
      chk("w8_rdy", 64'(rdy8), 64'd1);
      valid8 = 1'b1; aluop8 = 3'd1; fun8 = fn; a8 = x; b8 = y;
      step();
      valid8 = 1'b0;
      cyc = 1;
      while (!vo8 && cyc < 20) begin
        step();
        cyc++;
      end
      chk("w8_lat", 64'(cyc), 64'(elat));
      chk("w8_hi", 64'(hi8), ehi);
      chk("w8_lo", 64'(lo8), elo);
      chk("w8_dbz", 64'(dbz8), 64'(edbz));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
